// File: rtl/seg7_disp_ctrl_if.sv
// Connects the clock24 core to the six-digit display controller.
// Optional lamp-test request LAMP exists only when SEG7_LAMP_TEST_EN is defined.
interface seg7_disp_ctrl_if;
  logic [23:0] TIME;   // BCD {Ht,Hu,Mt,Mu,St,Su}
  logic        MODE;   // advance edit field (1-cycle pulse)
  logic        ACT;    // user adjusted the current field (1-cycle pulse)
`ifdef SEG7_LAMP_TEST_EN
  logic        LAMP;   // lamp test: force all segments on
`endif
  logic [23:0] DOUT;   // digit codes to the SEG7DEC instances
  logic [5:0]  DEN;    // per-digit enables, DEN[5]=Ht
  logic [1:0]  FIELD;  // 0=RUN 1=SET_H 2=SET_M 3=SET_S

`ifdef SEG7_LAMP_TEST_EN
  modport master (output TIME, MODE, ACT, LAMP, input DOUT, DEN, FIELD);
  modport slave  (input TIME, MODE, ACT, LAMP, output DOUT, DEN, FIELD);
`else
  modport master (output TIME, MODE, ACT, input DOUT, DEN, FIELD);
  modport slave  (input TIME, MODE, ACT, output DOUT, DEN, FIELD);
`endif
endinterface

// File: rtl/seg7_disp_ctrl.sv
// Display controller for the clock24 HH:MM:SS readout.
// Registers the BCD time, sequences the time-set edit cursor with field
// blinking and inactivity auto-return, and blanks a leading hour zero.
// Optional feature macro: SEG7_LAMP_TEST_EN (adds the LAMP lamp-test input).
module seg7_disp_ctrl #(
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned LZ_BLANK    = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  seg7_disp_ctrl_if.slave  bus
);

  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } field_e;

  field_e        field_q, field_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [23:0]   dout_q, dout_d;
  logic [5:0]    den_q, den_d;

  logic in_set_c;
  logic timeout_c;
  logic state_chg_c;

  assign in_set_c    = (field_q != ST_RUN);
  // Inactivity expiry only counts when no pulse arrives that cycle.
  assign timeout_c   = in_set_c && !bus.MODE && !bus.ACT && (to_cnt_q == TO_LAST);
  assign state_chg_c = (field_d != field_q);

  // Edit-cursor state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      field_q <= ST_RUN;
    end else begin
      field_q <= field_d;
    end
  end

  // Next field: MODE walks the ring, expiry returns to RUN.
  always_comb begin
    field_d = field_q;
    if (bus.MODE) begin
      case (field_q)
        ST_RUN:   field_d = ST_SET_H;
        ST_SET_H: field_d = ST_SET_M;
        ST_SET_M: field_d = ST_SET_S;
        ST_SET_S: field_d = ST_RUN;
        default:  field_d = ST_RUN;
      endcase
    end else if (timeout_c) begin
      field_d = ST_RUN;
    end
  end

  // Blink and inactivity counters; any field change or ACT restarts both visibly.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    to_cnt_d    = to_cnt_q;
    if (state_chg_c || !in_set_c || bus.ACT) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
      to_cnt_d    = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      to_cnt_q    <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Display outputs follow the post-edge field and phase.
  always_comb begin
    dout_d = bus.TIME;
    den_d  = 6'h3F;
    if (!phase_d) begin
      case (field_d)
        ST_SET_H: den_d[5:4] = 2'b00;
        ST_SET_M: den_d[3:2] = 2'b00;
        ST_SET_S: den_d[1:0] = 2'b00;
        default:  ;
      endcase
    end
    if ((LZ_BLANK != 32'd0) && (bus.TIME[23:20] == 4'h0)) begin
      den_d[5] = 1'b0;
    end
`ifdef SEG7_LAMP_TEST_EN
    // Lamp test overrides display only; sequencing keeps running.
    if (bus.LAMP) begin
      dout_d = 24'h888888;
      den_d  = 6'h3F;
    end
`endif
  end

  // Output registers; blank display out of reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dout_q <= '0;
      den_q  <= '0;
    end else begin
      dout_q <= dout_d;
      den_q  <= den_d;
    end
  end

  assign bus.DOUT  = dout_q;
  assign bus.DEN   = den_q;
  assign bus.FIELD = field_q;

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Scoreboard bench for seg7_disp_ctrl: directed scenarios plus random
// pulses/time values checked against an elapsed-time reference model.
module tb_seg7_disp_ctrl;

  localparam int unsigned BLINK_DIV   = 4;
  localparam int unsigned TIMEOUT_CYC = 20;
  localparam int unsigned LZ_BLANK    = 1;

  logic CLK = 1'b0;
  logic nRST;

  seg7_disp_ctrl_if bus ();

  seg7_disp_ctrl #(
    .BLINK_DIV   (BLINK_DIV),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LZ_BLANK    (LZ_BLANK)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [23:0] dout;
    logic [5:0]  den;
    logic [1:0]  field;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_edges  = 0;

  // Reference model: current field and cycles since entry/ACT.
  int m_field = 0;
  int m_since = 0;

  // Advance the model by one clock edge and queue the expected outputs.
  task automatic model_edge(input bit mode, input bit act, input logic [23:0] t, input bit lamp);
    exp_t e;
    logic [5:0] den;
    if (mode) begin
      m_field = (m_field + 1) % 4;
      m_since = 0;
    end else if (m_field != 0) begin
      if (act) m_since = 0;
      else     m_since = m_since + 1;
      if (m_since == int'(TIMEOUT_CYC)) begin
        m_field = 0;
        m_since = 0;
      end
    end
    den = 6'h3F;
    if (m_field != 0 && ((m_since / int'(BLINK_DIV)) % 2) == 1) begin
      for (int i = 0; i < 6; i++)
        if (i / 2 == 3 - m_field) den[i] = 1'b0;
    end
    if (LZ_BLANK != 0 && t[23:20] == 4'h0) den[5] = 1'b0;
    e.dout = t;
    if (lamp) begin
      e.dout = 24'h888888;
      den    = 6'h3F;
    end
    e.den   = den;
    e.field = 2'(m_field);
    sb_q.push_back(e);
  endtask

  task automatic apply(input bit mode, input bit act, input logic [23:0] t, input bit lamp);
    bus.MODE = mode;
    bus.ACT  = act;
    bus.TIME = t;
`ifdef SEG7_LAMP_TEST_EN
    bus.LAMP = lamp;
`endif
    model_edge(mode, act, t, lamp);
  endtask

  task automatic drive(input bit mode, input bit act, input logic [23:0] t, input bit lamp);
    @(negedge CLK);
    apply(mode, act, t, lamp);
  endtask

  task automatic idle(input int n, input logic [23:0] t);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, t, 1'b0);
  endtask

  task automatic check_reset(input string name);
    n_checks++;
    if (bus.DOUT === 24'h0 && bus.DEN === 6'h0 && bus.FIELD === 2'd0) n_pass++;
    else $display("FAIL %s got dout=%h den=%h field=%0d exp dout=000000 den=00 field=0",
                  name, bus.DOUT, bus.DEN, bus.FIELD);
  endtask

  // Async reset in mid-cycle, then release straight into a modelled edge.
  task automatic mid_reset(input logic [23:0] t);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1 check_reset("async_reset");
    bus.MODE = 1'b0;
    bus.ACT  = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST    = 1'b1;
    m_field = 0;
    m_since = 0;
    apply(1'b0, 1'b0, t, 1'b0);
  endtask

  function automatic logic [23:0] rand_time();
    logic [23:0] t;
    if ($urandom_range(15) == 0) t = 24'($urandom);
    else t = {4'($urandom_range(2)), 4'($urandom_range(9)), 4'($urandom_range(5)),
              4'($urandom_range(9)), 4'($urandom_range(5)), 4'($urandom_range(9))};
    return t;
  endfunction

  function automatic bit rand_lamp();
`ifdef SEG7_LAMP_TEST_EN
    return ($urandom_range(15) == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: compare every registered output against the queued expectation.
  always @(posedge CLK) begin
    exp_t e;
    exp_t got;
    #1;
    if (nRST === 1'b1 && sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {bus.DOUT, bus.DEN, bus.FIELD};
      n_edges++;
      n_checks++;
      if (got === e) n_pass++;
      else $display("FAIL out_edge%0d got dout=%h den=%h field=%0d exp dout=%h den=%h field=%0d",
                    n_edges, got.dout, got.den, got.field, e.dout, e.den, e.field);
    end
  end

  initial begin
    bus.MODE = 1'b0;
    bus.ACT  = 1'b0;
    bus.TIME = 24'h0;
`ifdef SEG7_LAMP_TEST_EN
    bus.LAMP = 1'b0;
`endif
    nRST = 1'b1;
    #3 nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check_reset("reset_state");

    // Release and load the first time value.
    @(negedge CLK);
    nRST = 1'b1;
    apply(1'b0, 1'b0, 24'h123456, 1'b0);
    idle(2, 24'h123456);

    // Leading-zero blanking in RUN.
    drive(1'b0, 1'b0, 24'h091500, 1'b0);
    drive(1'b0, 1'b0, 24'h101500, 1'b0);
    drive(1'b0, 1'b0, 24'h001500, 1'b0);

    // Blink in SET_H, then SET_M.
    drive(1'b1, 1'b0, 24'h123456, 1'b0);
    idle(10, 24'h123456);
    drive(1'b1, 1'b0, 24'h123456, 1'b0);
    idle(6, 24'h123456);

    // Timeout from SET_M with no activity.
    idle(20, 24'h123456);
    // Re-enter SET_M, ACT at cycle 10, then let it expire.
    drive(1'b1, 1'b0, 24'h123456, 1'b0);
    drive(1'b1, 1'b0, 24'h123456, 1'b0);
    idle(9, 24'h123456);
    drive(1'b0, 1'b1, 24'h123456, 1'b0);
    idle(25, 24'h123456);

    // Full MODE ring, then MODE+ACT together in SET_S.
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 24'h235959, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 24'h235959, 1'b0);
    idle(5, 24'h235959);
    drive(1'b1, 1'b1, 24'h235959, 1'b0);
    idle(3, 24'h235959);

`ifdef SEG7_LAMP_TEST_EN
    // Lamp test during the hidden phase of SET_H.
    drive(1'b1, 1'b0, 24'h123456, 1'b0);
    idle(5, 24'h123456);
    drive(1'b0, 1'b0, 24'h123456, 1'b1);
    drive(1'b0, 1'b0, 24'h123456, 1'b1);
    idle(8, 24'h123456);
`endif

    // Reset while editing.
    drive(1'b1, 1'b0, 24'h071234, 1'b0);
    idle(5, 24'h071234);
    mid_reset(24'h071234);
    idle(2, 24'h071234);

    // Random: frequent pulses.
    for (int k = 0; k < 1500; k++)
      drive(($urandom_range(19) == 0), ($urandom_range(9) == 0), rand_time(), rand_lamp());
    // Random: sparse pulses so timeouts occur.
    for (int k = 0; k < 600; k++)
      drive(($urandom_range(39) == 0), ($urandom_range(63) == 0), rand_time(), rand_lamp());

    idle(1, 24'h000000);
    @(posedge CLK);
    #3;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain got pending=%0d exp pending=0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
